fifo_fwft_ctrl: RTL and testbench

- Synchronous FIFO with first-word-fall-through on the read side.
- Write side is a plain strobe interface. Read side is a valid/ready stream.
- Storage is an internal dual-port array with synchronous read (1-cycle latency): one port is write-only from the write side, the other is read-only from the prefetch logic.
- Sits between a producer and a consumer in the same clock domain.

---
 rtl/fifo_fwft_ctrl.sv | 117 +++++++++++
 tb/tb_fifo_fwft_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_fwft_ctrl.sv
// First-word-fall-through FIFO controller with internal synchronous-read storage.
// The write side is a plain strobe. The read side is a valid/ready stream fed by a
// one-deep prefetch through the RAM read register.
// Optional macro FIFO_ALMOST_FLAGS_EN adds the in_AFULL/out_AEMPTY level flags.
module fifo_fwft_ctrl #(
    parameter int unsigned DATA = 16,
    parameter int unsigned ADDR = 5
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    parameter int unsigned AF_LEVEL = (2 ** ADDR) - 4,
    parameter int unsigned AE_LEVEL = 4
`endif
) (
    input  logic            clK,
    input  logic            rst_N,
    input  logic            in_WR,
    input  logic [DATA-1:0] in_data_IN,
    output logic            in_FULL,
    output logic            out_VALID,
    input  logic            out_READY,
    output logic [DATA-1:0] out_data_OUT,
    output logic [ADDR:0]   COUNT,
    output logic            err_OVF
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    output logic            in_AFULL,
    output logic            out_AEMPTY
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR;
    localparam logic [ADDR:0] DepthCnt = (ADDR + 1)'(DEPTH);
`ifdef FIFO_ALMOST_FLAGS_EN
    localparam logic [ADDR:0] AfLevel = (ADDR + 1)'(AF_LEVEL);
    localparam logic [ADDR:0] AeLevel = (ADDR + 1)'(AE_LEVEL);
`endif

    logic [DATA-1:0] mem [DEPTH];
    logic [DATA-1:0] ram_q;
    logic [ADDR-1:0] wr_ptr_q;
    logic [ADDR-1:0] rd_ptr_q;
    logic [ADDR:0]   count_q;
    logic [ADDR:0]   count_d;
    logic [ADDR:0]   arr_cnt;
    logic            rd_busy_q;
    logic            wr_acc;
    logic            pop;
    logic            issue;

    assign COUNT = count_q;

    // Handshake decode, array occupancy and prefetch issue decision.
    always_comb begin
        wr_acc  = in_WR && !in_FULL;
        pop     = out_VALID && out_READY;
        // Words still sitting in the array; COUNT also covers the two prefetch stages.
        // Using COUNT rather than the pointer difference tells full from empty.
        arr_cnt = count_q - (ADDR + 1)'(rd_busy_q) - (ADDR + 1)'(out_VALID);
        // Only one read may be in flight, and the output slot must be free or
        // vacating this cycle.
        issue   = (arr_cnt != '0) && !rd_busy_q && (!out_VALID || pop);
        count_d = count_q + (ADDR + 1)'(wr_acc) - (ADDR + 1)'(pop);
    end

    // Storage: write port from the producer, synchronous read port for the prefetch.
    always_ff @(posedge clK) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= in_data_IN;
        end
        if (issue) begin
            ram_q <= mem[rd_ptr_q];
        end
    end

    // Pointers, prefetch pipeline, output register and status flags.
    always_ff @(posedge clK or negedge rst_N) begin
        if (!rst_N) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_busy_q    <= 1'b0;
            count_q      <= '0;
            in_FULL      <= 1'b0;
            out_VALID    <= 1'b0;
            out_data_OUT <= '0;
            err_OVF      <= 1'b0;
`ifdef FIFO_ALMOST_FLAGS_EN
            in_AFULL     <= 1'b0;
            out_AEMPTY   <= 1'b1;
`endif
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + ADDR'(1);
            end
            if (issue) begin
                rd_ptr_q <= rd_ptr_q + ADDR'(1);
            end
            rd_busy_q <= issue;
            // A completing read always finds the output slot free: issue waited for it.
            if (rd_busy_q) begin
                out_data_OUT <= ram_q;
                out_VALID    <= 1'b1;
            end else if (pop) begin
                out_VALID <= 1'b0;
            end
            count_q <= count_d;
            in_FULL <= (count_d == DepthCnt);
            if (in_WR && in_FULL) begin
                err_OVF <= 1'b1;
            end
`ifdef FIFO_ALMOST_FLAGS_EN
            in_AFULL   <= (count_d >= AfLevel);
            out_AEMPTY <= (count_d <= AeLevel);
`endif
        end
    end

endmodule

// File: tb/tb_fifo_fwft_ctrl.sv
// Directed bench for fifo_fwft_ctrl (DATA=16, ADDR=5, DEPTH=32).
module tb_fifo_fwft_ctrl;

    logic        clK;
    logic        rst_N;
    logic        in_WR;
    logic [15:0] in_data_IN;
    logic        in_FULL;
    logic        out_VALID;
    logic        out_READY;
    logic [15:0] out_data_OUT;
    logic [5:0]  COUNT;
    logic        err_OVF;
`ifdef FIFO_ALMOST_FLAGS_EN
    logic        in_AFULL;
    logic        out_AEMPTY;
`endif

    int compared = 0;
    int mismatched = 0;

    fifo_fwft_ctrl #(
        .DATA(16),
        .ADDR(5)
    ) dut (
        .clK          (clK),
        .rst_N        (rst_N),
        .in_WR        (in_WR),
        .in_data_IN   (in_data_IN),
        .in_FULL      (in_FULL),
        .out_VALID    (out_VALID),
        .out_READY    (out_READY),
        .out_data_OUT (out_data_OUT),
        .COUNT        (COUNT),
        .err_OVF      (err_OVF)
`ifdef FIFO_ALMOST_FLAGS_EN
        ,
        .in_AFULL     (in_AFULL),
        .out_AEMPTY   (out_AEMPTY)
`endif
    );

    initial begin
        clK = 1'b0;
        forever #5 clK = ~clK;
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clK);
        #1;
    endtask

    task automatic test_reset();
        rst_N = 1'b0; in_WR = 1'b0; in_data_IN = '0; out_READY = 1'b0;
        #12;
        compared++;
        if (COUNT !== 6'd0 || in_FULL !== 1'b0 || out_VALID !== 1'b0 ||
            out_data_OUT !== 16'h0 || err_OVF !== 1'b0) begin
            mismatched++;
            $display("FAIL reset: cnt=%0d full=%b vld=%b data=%h ovf=%b required 0/0/0/0000/0",
                     COUNT, in_FULL, out_VALID, out_data_OUT, err_OVF);
        end
        tick();
        rst_N = 1'b1;
    endtask

    task automatic test_single();
        in_WR = 1'b1; in_data_IN = 16'hA5A5;
        tick();  // edge 1
        in_WR = 1'b0;
        compared++;
        if (COUNT !== 6'd1 || out_VALID !== 1'b0) begin
            mismatched++;
            $display("FAIL single_e1: cnt=%0d vld=%b required 1/0", COUNT, out_VALID);
        end
        tick();  // edge 2
        compared++;
        if (out_VALID !== 1'b0) begin
            mismatched++;
            $display("FAIL single_e2_valid: got %b required 0", out_VALID);
        end
        tick();  // edge 3
        compared++;
        if (out_VALID !== 1'b1 || out_data_OUT !== 16'hA5A5 || COUNT !== 6'd1) begin
            mismatched++;
            $display("FAIL single_e3: vld=%b data=%h cnt=%0d required 1/a5a5/1",
                     out_VALID, out_data_OUT, COUNT);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            compared++;
            if (out_VALID !== 1'b1 || out_data_OUT !== 16'hA5A5 || COUNT !== 6'd1) begin
                mismatched++;
                $display("FAIL single_hold%0d: vld=%b data=%h cnt=%0d required 1/a5a5/1",
                         i, out_VALID, out_data_OUT, COUNT);
            end
        end
        out_READY = 1'b1;
        tick();
        out_READY = 1'b0;
        compared++;
        if (out_VALID !== 1'b0 || COUNT !== 6'd0) begin
            mismatched++;
            $display("FAIL single_pop: vld=%b cnt=%0d required 0/0", out_VALID, COUNT);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 32; i++) begin
            in_WR = 1'b1; in_data_IN = 16'(i);
            tick();
            if (i == 30) begin
                compared++;
                if (in_FULL !== 1'b0 || COUNT !== 6'd31) begin
                    mismatched++;
                    $display("FAIL fill_31: full=%b cnt=%0d required 0/31", in_FULL, COUNT);
                end
            end
        end
        compared++;
        if (in_FULL !== 1'b1 || COUNT !== 6'd32 || err_OVF !== 1'b0) begin
            mismatched++;
            $display("FAIL fill_32: full=%b cnt=%0d ovf=%b required 1/32/0",
                     in_FULL, COUNT, err_OVF);
        end
        in_data_IN = 16'h0BAD;
        tick();
        in_WR = 1'b0;
        compared++;
        if (err_OVF !== 1'b1 || COUNT !== 6'd32 || in_FULL !== 1'b1) begin
            mismatched++;
            $display("FAIL overflow: ovf=%b cnt=%0d full=%b required 1/32/1",
                     err_OVF, COUNT, in_FULL);
        end
        compared++;
        if (out_VALID !== 1'b1 || out_data_OUT !== 16'h0) begin
            mismatched++;
            $display("FAIL fill_head: vld=%b data=%h required 1/0000", out_VALID, out_data_OUT);
        end
    endtask

    task automatic test_drain();
        int idx = 0;
        out_READY = 1'b1;
        for (int cyc = 0; cyc < 200 && idx < 32; cyc++) begin
            if (out_VALID === 1'b1) begin
                compared++;
                if (out_data_OUT !== 16'(idx)) begin
                    mismatched++;
                    $display("FAIL drain_word%0d: got %h required %h", idx, out_data_OUT, 16'(idx));
                end
                idx++;
            end
            tick();
        end
        compared++;
        if (idx != 32) begin
            mismatched++;
            $display("FAIL drain_timeout: got %0d words required 32", idx);
        end
        tick();
        out_READY = 1'b0;
        compared++;
        if (out_VALID !== 1'b0 || COUNT !== 6'd0 || in_FULL !== 1'b0 || err_OVF !== 1'b1) begin
            mismatched++;
            $display("FAIL drain_end: vld=%b cnt=%0d full=%b ovf=%b required 0/0/0/1",
                     out_VALID, COUNT, in_FULL, err_OVF);
        end
    endtask

    task automatic test_back_to_back();
        int q[$];
        int next_word = 0;
        int mc = 0;
        int cyc = 0;
        bit wr, rdy, acc, popb, prev_valid;
        logic [15:0] prev_data;
        while ((next_word < 100 || q.size() > 0) && cyc < 3000) begin
            wr  = (next_word < 100) && ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 1) == 1);
            in_WR = wr; in_data_IN = 16'(next_word); out_READY = rdy;
            acc  = wr && (mc != 32);
            popb = (out_VALID === 1'b1) && rdy;
            if (popb) begin
                compared++;
                if (q.size() == 0) begin
                    mismatched++;
                    $display("FAIL b2b_underflow: got %h required no data", out_data_OUT);
                end else begin
                    if (out_data_OUT !== 16'(q[0])) begin
                        mismatched++;
                        $display("FAIL b2b_data: got %h required %h", out_data_OUT, 16'(q[0]));
                    end
                    void'(q.pop_front());
                end
            end
            if (acc) begin
                q.push_back(next_word);
                next_word++;
            end
            prev_valid = (out_VALID === 1'b1);
            prev_data  = out_data_OUT;
            tick();
            cyc++;
            mc = mc + int'(acc) - int'(popb);
            compared++;
            if (COUNT !== 6'(mc)) begin
                mismatched++;
                $display("FAIL b2b_count cyc%0d: got %0d required %0d", cyc, COUNT, mc);
            end
            if (prev_valid && !popb) begin
                compared++;
                if (out_VALID !== 1'b1 || out_data_OUT !== prev_data) begin
                    mismatched++;
                    $display("FAIL b2b_hold cyc%0d: vld=%b data=%h required 1/%h",
                             cyc, out_VALID, out_data_OUT, prev_data);
                end
            end
        end
        in_WR = 1'b0; out_READY = 1'b0;
        compared++;
        if (cyc >= 3000) begin
            mismatched++;
            $display("FAIL b2b_timeout: got %0d words left required 0", q.size());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) begin
            in_WR = 1'b1; in_data_IN = 16'(16'h100 + i);
            tick();
        end
        in_WR = 1'b0;
        tick(); tick();
        compared++;
        if (COUNT !== 6'd7 || out_VALID !== 1'b1 || out_data_OUT !== 16'h0100) begin
            mismatched++;
            $display("FAIL mid_pre: cnt=%0d vld=%b data=%h required 7/1/0100",
                     COUNT, out_VALID, out_data_OUT);
        end
        #3;
        rst_N = 1'b0;
        #1;
        compared++;
        if (COUNT !== 6'd0 || in_FULL !== 1'b0 || out_VALID !== 1'b0 ||
            out_data_OUT !== 16'h0 || err_OVF !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_async: cnt=%0d full=%b vld=%b data=%h ovf=%b required 0/0/0/0000/0",
                     COUNT, in_FULL, out_VALID, out_data_OUT, err_OVF);
        end
        tick();
        rst_N = 1'b1;
        tick();
        in_WR = 1'b1; in_data_IN = 16'h1234;
        tick();
        in_WR = 1'b0;
        compared++;
        if (COUNT !== 6'd1 || out_VALID !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_w1: cnt=%0d vld=%b required 1/0", COUNT, out_VALID);
        end
        tick();
        compared++;
        if (out_VALID !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_w2: vld=%b required 0", out_VALID);
        end
        tick();
        compared++;
        if (out_VALID !== 1'b1 || out_data_OUT !== 16'h1234) begin
            mismatched++;
            $display("FAIL mid_read: vld=%b data=%h required 1/1234", out_VALID, out_data_OUT);
        end
    endtask

`ifdef FIFO_ALMOST_FLAGS_EN
    task automatic test_almost();
        int mc = 0;
        rst_N = 1'b0;
        #1;
        compared++;
        if (in_AFULL !== 1'b0 || out_AEMPTY !== 1'b1) begin
            mismatched++;
            $display("FAIL almost_reset: af=%b ae=%b required 0/1", in_AFULL, out_AEMPTY);
        end
        tick();
        rst_N = 1'b1;
        for (int i = 0; i < 28; i++) begin
            in_WR = 1'b1; in_data_IN = 16'(i);
            tick();
            mc++;
            if (mc == 27) begin
                compared++;
                if (in_AFULL !== 1'b0) begin
                    mismatched++;
                    $display("FAIL almost_af27: got %b required 0", in_AFULL);
                end
            end
        end
        in_WR = 1'b0;
        compared++;
        if (in_AFULL !== 1'b1 || COUNT !== 6'd28) begin
            mismatched++;
            $display("FAIL almost_af28: af=%b cnt=%0d required 1/28", in_AFULL, COUNT);
        end
        for (int cyc = 0; cyc < 400 && mc > 0; cyc++) begin
            if (out_VALID === 1'b1) begin
                out_READY = 1'b1;
                tick();
                out_READY = 1'b0;
                mc--;
                if (mc == 27 || mc == 5 || mc == 4) begin
                    compared++;
                    if (COUNT !== 6'(mc) || in_AFULL !== 1'b0 || out_AEMPTY !== (mc == 4)) begin
                        mismatched++;
                        $display("FAIL almost_at%0d: cnt=%0d af=%b ae=%b required %0d/0/%b",
                                 mc, COUNT, in_AFULL, out_AEMPTY, mc, (mc == 4));
                    end
                end
            end else begin
                tick();
            end
        end
        compared++;
        if (mc != 0) begin
            mismatched++;
            $display("FAIL almost_drain: got %0d left required 0", mc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_back_to_back();
        test_reset_mid();
`ifdef FIFO_ALMOST_FLAGS_EN
        test_almost();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
